spi_mem_responder: RTL and testbench

SPI mode-0 responder emulating a small byte-addressable serial SRAM. It decodes READ (0x03) and WRITE (0x02) commands, each followed by a 16-bit address, and supports sequential byte access with address auto-increment. It is the target-side counterpart of the chip's single-byte SPI read master. It serves as an on-chip loopback/test target and as a synthesizable bench model, with a host-side port for preloading and inspecting memory.

---
 rtl/spi_mem_pkg.sv | 23 ++
 rtl/spi_mem_responder_sync.sv | 42 ++++
 rtl/spi_mem_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// ---------------------------------------------------------------------------
// spi_mem_pkg
// Shared constants and types for the SPI memory responder:
//   CMD_READ / CMD_WRITE  - default opcodes
//   SCK_MIN_PHASE         - minimum SCK high/low phase (and CS setup) in clk
//   state_t               - responder FSM states
// ---------------------------------------------------------------------------
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam int         SCK_MIN_PHASE = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_mem_responder_sync.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for an asynchronous input plus a third flop that
// remembers the previous synchronized value for edge detection.
// Ports:
//   clk, rst_n - system clock, synchronous active-low reset
//   din        - asynchronous input
//   dout       - synchronized level (2 clk latency)
//   rise, fall - single-cycle pulses on a synchronized 0->1 / 1->0 change
// All flops reset to 0, so a line that is already low when reset releases
// never produces a fall pulse; it has to be seen high first.
// ---------------------------------------------------------------------------
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign dout = sync_reg;
    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_mem_responder.sv
// ---------------------------------------------------------------------------
// spi_mem_responder
// SPI mode-0 responder emulating a small byte-addressable serial SRAM.
// Commands: READ (CMD_READ) and, when built with SPI_RESP_WRITE_EN defined,
// WRITE (CMD_WRITE), each followed by a 16-bit address; data bytes then
// stream with address auto-increment and wrap at 2^ADDR_BITS.
// Without SPI_RESP_WRITE_EN the write opcode is treated as unknown and the
// memory is writable only through the host port.
// Ports:
//   clk, rst_n        - system clock, synchronous active-low reset
//   ena               - block enable; low forces IDLE and releases MISO
//   cs_n, sck, mosi   - SPI pins, asynchronous, oversampled on clk
//   miso, miso_oe     - SPI data out and its output enable
//   busy              - transaction active (CS seen low)
//   host_we/addr/wdata- host write port (priority over SPI writes)
//   host_rdata        - registered read of mem[host_addr]
// ADDR_BITS must be in 1..8: the address is taken from the low address byte.
// ---------------------------------------------------------------------------
module spi_mem_responder #(
    parameter int         ADDR_BITS = 4,
    parameter logic [7:0] CMD_READ  = spi_mem_pkg::CMD_READ,
    parameter logic [7:0] CMD_WRITE = spi_mem_pkg::CMD_WRITE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cs_n,
    input  logic                 sck,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 busy,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata
);

    import spi_mem_pkg::*;

    localparam int DEPTH = 1 << ADDR_BITS;

`ifdef SPI_RESP_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    // ---------------- input synchronization ----------------
    logic cs_sync, cs_rise, cs_fall;
    logic sck_sync, sck_rise, sck_fall;
    logic mosi_meta_reg, mosi_sync_reg;

    spi_sync_edge u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .dout  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .dout  (sck_sync),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // mosi has the same 2-flop latency as sck, so it lines up with sck_rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
        end else begin
            mosi_meta_reg <= mosi;
            mosi_sync_reg <= mosi_meta_reg;
        end
    end

    // ---------------- state ----------------
    state_t                 state_reg;
    logic [2:0]             bit_cnt_reg;
    logic [6:0]             rx_reg;
    logic [7:0]             tx_reg;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic                   addr_byte_reg;  // 0: high address byte, 1: low
    logic                   cmd_wr_reg;
    logic                   miso_reg;
    logic                   armed_reg;      // cs_n seen high since reset
    logic [7:0]             host_rdata_reg;
    logic [7:0]             mem [DEPTH];

    logic [7:0]             rx_next;
    logic [ADDR_BITS-1:0]   addr_inc;
    logic                   active;

    assign rx_next  = {rx_reg, mosi_sync_reg};
    assign addr_inc = addr_reg + ADDR_BITS'(1);

    // After reset the FSM must not join a transaction already in progress,
    // so the pin outputs stay off until cs_n has been observed high.
    assign active  = ena & armed_reg & ~cs_sync;
    assign miso_oe = active;
    assign busy    = active;
    assign miso    = miso_reg & active;

    assign host_rdata = host_rdata_reg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_reg        <= 7'd0;
            tx_reg        <= 8'h00;
            addr_reg      <= '0;
            addr_byte_reg <= 1'b0;
            cmd_wr_reg    <= 1'b0;
            miso_reg      <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            if (cs_rise) begin
                armed_reg <= 1'b1;
            end
            if (!ena || cs_sync) begin
                // Any partial byte is simply dropped here.
                state_reg <= IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Start only on a fresh CS fall so that re-enabling
                        // mid-transaction does not decode garbage.
                        if (cs_fall && armed_reg) begin
                            state_reg     <= CMD;
                            bit_cnt_reg   <= 3'd0;
                            addr_byte_reg <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx_reg      <= rx_next[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (rx_next == CMD_READ) begin
                                    cmd_wr_reg <= 1'b0;
                                    state_reg  <= ADDR;
                                end else if (WRITE_EN && (rx_next == CMD_WRITE)) begin
                                    cmd_wr_reg <= 1'b1;
                                    state_reg  <= ADDR;
                                end else begin
                                    state_reg <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            rx_reg      <= rx_next[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                addr_byte_reg <= ~addr_byte_reg;
                                // The high address byte is discarded.
                                if (addr_byte_reg) begin
                                    addr_reg <= rx_next[ADDR_BITS-1:0];
                                    if (cmd_wr_reg) begin
                                        state_reg <= WR;
                                    end else begin
                                        state_reg <= RD;
                                        tx_reg    <= mem[rx_next[ADDR_BITS-1:0]];
                                    end
                                end
                            end
                        end
                    end
                    RD: begin
                        if (sck_fall) begin
                            miso_reg <= tx_reg[7];
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                        end else if (sck_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                addr_reg <= addr_inc;
                                tx_reg   <= mem[addr_inc];
                            end
                        end
                    end
`ifdef SPI_RESP_WRITE_EN
                    WR: begin
                        if (sck_rise) begin
                            rx_reg      <= rx_next[6:0];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                addr_reg <= addr_inc;
                            end
                        end
                    end
`endif
                    IGNORE: begin
                        miso_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- memory ----------------
`ifdef SPI_RESP_WRITE_EN
    logic spi_we;
    assign spi_we = (state_reg == WR) && sck_rise && (bit_cnt_reg == 3'd7)
                    && ena && !cs_sync;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (host_we) begin
            // Host wins a same-cycle collision; the SPI byte is lost.
            mem[host_addr] <= host_wdata;
        end
`ifdef SPI_RESP_WRITE_EN
        else if (spi_we) begin
            mem[addr_reg] <= rx_next;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            host_rdata_reg <= 8'h00;
        end else begin
            host_rdata_reg <= mem[host_addr];
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_responder
// Directed bench for spi_mem_responder: a table of SPI transactions with
// host preloads and host read-back checks, plus hand sequences for busy
// timing, partial writes and reset in the middle of a read.
// Expectations for writes follow SPI_RESP_WRITE_EN.
// ---------------------------------------------------------------------------
module tb_spi_mem_responder;

    import spi_mem_pkg::*;

`ifdef SPI_RESP_WRITE_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif

    localparam int PH = SCK_MIN_PHASE + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       busy;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_mem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cs_n       (cs_n),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .busy       (busy),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    typedef struct {
        int         pre_n;
        logic [3:0] pa0;
        logic [7:0] pd0;
        logic [3:0] pa1;
        logic [7:0] pd1;
        logic [7:0] cmd;
        logic [15:0] addr;
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         chk_rx;
        logic [7:0] e0;
        logic [7:0] e1;
        int         nchk;
        logic [3:0] ca0;
        logic [7:0] cd0;
        logic [3:0] ca1;
        logic [7:0] cd1;
    } vec_t;

    vec_t vecs [9];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick(1);
        host_we    = 1'b0;
    endtask

    task automatic host_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        tick(2);
        check(name, host_rdata, exp);
    endtask

    // Mode 0: drive MOSI with SCK low, sample MISO just before each rise.
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = d[7-i];
            tick(PH);
            r    = {r[6:0], miso};
            sck  = 1'b1;
            tick(PH);
            sck  = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] r;
        logic [7:0] rx0;
        logic [7:0] rx1;
        rx0 = 8'h00;
        rx1 = 8'h00;
        if (v.pre_n > 0) host_write(v.pa0, v.pd0);
        if (v.pre_n > 1) host_write(v.pa1, v.pd1);
        cs_n = 1'b0;
        tick(PH);
        spi_bits(v.cmd, 8, r);
        spi_bits(v.addr[15:8], 8, r);
        spi_bits(v.addr[7:0], 8, r);
        if (v.nb > 0) spi_bits(v.b0, 8, rx0);
        if (v.nb > 1) spi_bits(v.b1, 8, rx1);
        tick(PH);
        cs_n = 1'b1;
        tick(2 * PH);
        $display("vec %0d: cmd=%02h addr=%04h rx=%02h %02h", idx, v.cmd, v.addr, rx0, rx1);
        if (v.chk_rx) begin
            check($sformatf("v%0d_rx0", idx), rx0, v.e0);
            if (v.nb > 1) check($sformatf("v%0d_rx1", idx), rx1, v.e1);
        end
        if (v.nchk > 0) host_check($sformatf("v%0d_mem%0d", idx, v.ca0), v.ca0, v.cd0);
        if (v.nchk > 1) host_check($sformatf("v%0d_mem%0d", idx, v.ca1), v.ca1, v.cd1);
    endtask

    initial begin
        logic [7:0] r;

        //        pre a0  d0     a1 d1     cmd    addr      nb b0     b1     rx e0                      e1                      nchk ca0 cd0                  ca1 cd1
        vecs[0] = '{1, 4'd3,  8'h5A, 4'd0, 8'h00, 8'h03, 16'h0003, 1, 8'h00, 8'h00, 1, 8'h5A,                  8'h00,                  1, 4'd3,  8'h5A,                  4'd0, 8'h00};
        vecs[1] = '{2, 4'd15, 8'hC3, 4'd0, 8'h81, 8'h03, 16'h000F, 2, 8'h00, 8'h00, 1, 8'hC3,                  8'h81,                  2, 4'd15, 8'hC3,                  4'd0, 8'h81};
        vecs[2] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h02, 16'h0004, 2, 8'hA5, 8'h3C, 0, 8'h00,                  8'h00,                  2, 4'd4,  (WREN ? 8'hA5 : 8'h00), 4'd5, (WREN ? 8'h3C : 8'h00)};
        vecs[3] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h03, 16'h0004, 2, 8'h00, 8'h00, 1, (WREN ? 8'hA5 : 8'h00), (WREN ? 8'h3C : 8'h00), 0, 4'd0,  8'h00,                  4'd0, 8'h00};
        vecs[4] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h03, 16'hAB13, 1, 8'h00, 8'h00, 1, 8'h5A,                  8'h00,                  0, 4'd0,  8'h00,                  4'd0, 8'h00};
        vecs[5] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h9F, 16'h0003, 2, 8'hFF, 8'h55, 1, 8'h00,                  8'h00,                  1, 4'd3,  8'h5A,                  4'd0, 8'h00};
        vecs[6] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h03, 16'h0003, 1, 8'h00, 8'h00, 1, 8'h5A,                  8'h00,                  0, 4'd0,  8'h00,                  4'd0, 8'h00};
        vecs[7] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h02, 16'h000F, 2, 8'h11, 8'h22, 0, 8'h00,                  8'h00,                  2, 4'd15, (WREN ? 8'h11 : 8'hC3), 4'd0, (WREN ? 8'h22 : 8'h81)};
        vecs[8] = '{0, 4'd0,  8'h00, 4'd0, 8'h00, 8'h03, 16'h000F, 2, 8'h00, 8'h00, 1, (WREN ? 8'h11 : 8'hC3), (WREN ? 8'h22 : 8'h81), 0, 4'd0,  8'h00,                  4'd0, 8'h00};

        rst_n      = 1'b0;
        ena        = 1'b1;
        cs_n       = 1'b1;
        sck        = 1'b0;
        mosi       = 1'b0;
        host_we    = 1'b0;
        host_addr  = 4'd0;
        host_wdata = 8'h00;

        // Reset state
        tick(3);
        check("rst_miso",    {7'd0, miso},    8'h00);
        check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_busy",    {7'd0, busy},    8'h00);
        check("rst_rdata",   host_rdata,      8'h00);
        rst_n = 1'b1;
        tick(2 * PH);

        // busy / miso_oe follow cs_n by 2 clk; ena low releases them
        cs_n = 1'b0;
        tick(1);
        check("busy_lag1", {7'd0, busy}, 8'h00);
        tick(1);
        check("busy_rise", {7'd0, busy},    8'h01);
        check("oe_rise",   {7'd0, miso_oe}, 8'h01);
        ena = 1'b0;
        #1;
        check("oe_ena_low", {7'd0, miso_oe}, 8'h00);
        ena = 1'b1;
        tick(1);
        cs_n = 1'b1;
        tick(1);
        check("busy_hold1", {7'd0, busy}, 8'h01);
        tick(1);
        check("busy_fall", {7'd0, busy}, 8'h00);
        tick(2 * PH);

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Partial write is discarded
        cs_n = 1'b0;
        tick(PH);
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h06, 8, r);
        spi_bits(8'hFF, 4, r);
        tick(PH);
        cs_n = 1'b1;
        tick(1);
        check("partial_busy_hold", {7'd0, busy}, 8'h01);
        tick(1);
        check("partial_busy_fall", {7'd0, busy}, 8'h00);
        tick(2 * PH);
        host_check("partial_mem6", 4'd6, 8'h00);

        // Reset in the middle of a read data phase
        cs_n = 1'b0;
        tick(PH);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 4, r);
        check("midrd_nibble", r, 8'h05);
        rst_n = 1'b0;
        tick(1);
        check("midrst_miso",    {7'd0, miso},    8'h00);
        check("midrst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("midrst_busy",    {7'd0, busy},    8'h00);
        rst_n = 1'b1;
        tick(2 * PH);
        check("postrst_busy_cs_low", {7'd0, busy}, 8'h00);
        for (int a = 0; a < 16; a++) begin
            host_check($sformatf("postrst_mem%0d", a), 4'(a), 8'h00);
        end
        cs_n = 1'b1;
        tick(2 * PH);
        host_write(4'd9, 8'hE7);
        cs_n = 1'b0;
        tick(PH);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h09, 8, r);
        spi_bits(8'h00, 8, r);
        tick(PH);
        cs_n = 1'b1;
        tick(2 * PH);
        check("postrst_read9", r, 8'hE7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
